// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 mouse host.
//   - command/response bytes used by the init sequencer
//   - err_code_e: abort causes reported on ps2_mouse_init_ctrl.err_code
//   - tx_state_e / seq_state_e: transmitter and sequencer state encodings
//   - odd_parity / step_rsp helpers
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  // Transmitter result codes (tx_err). Values line up with err_code_e.
  localparam logic [1:0] TXE_NONE    = 2'd0;
  localparam logic [1:0] TXE_TIMEOUT = 2'd1;
  localparam logic [1:0] TXE_NO_ACK  = 2'd2;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_TX_TIMEOUT   = 3'd1,
    ERR_NO_ACK       = 3'd2,
    ERR_RESP_TIMEOUT = 3'd3,
    ERR_UNEXPECTED   = 3'd4,
    ERR_RETRY        = 3'd5,
    ERR_RX           = 3'd6,
    ERR_BAT          = 3'd7
  } err_code_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_RTS,
    TX_BITS,
    TX_ACK,
    TX_ACK_IDLE
  } tx_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_TX,
    SEQ_RESP
  } seq_state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Byte that moves each step forward: S0/S3 wait for ACK, S1 BAT, S2 ID.
  function automatic logic [7:0] step_rsp(input logic [1:0] step);
    case (step)
      2'd1:    return RSP_BAT_OK;
      2'd2:    return RSP_ID;
      default: return RSP_ACK;
    endcase
  endfunction

endpackage

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
//   clk, rst_n           system clock, async active-low reset
//   ps2_clk_in/data_in   raw pad inputs (asynchronous, synchronized here)
//   tx_start, tx_byte    one-cycle request with the byte to send (while idle)
//   tx_busy              high from inhibit until the device releases the bus
//   tx_done, tx_err      one-cycle completion pulse; tx_err = TXE_* code
//   clk_oe, data_oe      1 = pull the pad low (open drain)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TX_TIMEOUT     = 375000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] tx_err,
  output logic       clk_oe,
  output logic       data_oe
);

  localparam int CMAX = (INHIBIT_CYCLES > TX_TIMEOUT) ? INHIBIT_CYCLES : TX_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TX_TIMEOUT - 1);

  // 2-flop synchronizers plus one delay stage for edge detection.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_d;
  logic       clk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_d     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_d     <= clk_sync[1];
    end
  end

  assign clk_fall = clk_d & ~clk_sync[1];

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [3:0]    edges;
  logic [8:0]    shreg;   // {parity, d7..d0}, shifted out LSB first
  logic          in_line;
  logic          gap_expired;

  // States where the device owns the clock and the edge-gap watchdog runs.
  assign in_line     = (state == TX_BITS) || (state == TX_ACK) || (state == TX_ACK_IDLE);
  assign gap_expired = !clk_fall && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      edges   <= '0;
      shreg   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= TXE_NONE;
    end else begin
      tx_done <= 1'b0;
      if (in_line) cnt <= clk_fall ? '0 : cnt + 1'b1;

      if (in_line && gap_expired) begin
        data_oe <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
        tx_err  <= TXE_TIMEOUT;
        state   <= TX_IDLE;
      end else begin
        case (state)
          TX_IDLE: begin
            if (tx_start) begin
              shreg   <= {odd_parity(tx_byte), tx_byte};
              cnt     <= CW'(1);
              edges   <= '0;
              clk_oe  <= 1'b1;
              tx_busy <= 1'b1;
              tx_err  <= TXE_NONE;
              state   <= TX_INHIBIT;
            end
          end
          // cnt starts at 1 so that clk_oe stays high exactly INHIBIT_CYCLES
          // cycles: data_oe rises on the last of them, clk_oe drops one later.
          TX_INHIBIT: begin
            if (cnt >= INH_LAST) begin
              data_oe <= 1'b1;
              state   <= TX_RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TX_RTS: begin
            clk_oe <= 1'b0;
            cnt    <= '0;
            state  <= TX_BITS;
          end
          // Edges 1..9 present d0..d7 then parity; edge 10 releases for stop.
          TX_BITS: begin
            if (clk_fall) begin
              edges <= edges + 1'b1;
              if (edges == 4'd9) begin
                data_oe <= 1'b0;
                state   <= TX_ACK;
              end else begin
                data_oe <= ~shreg[0];
                shreg   <= {1'b0, shreg[8:1]};
              end
            end
          end
          TX_ACK: begin
            if (clk_fall) begin
              if (data_sync[1]) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                tx_err  <= TXE_NO_ACK;
                state   <= TX_IDLE;
              end else begin
                state <= TX_ACK_IDLE;
              end
            end
          end
          TX_ACK_IDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= TX_IDLE;
            end
          end
          default: begin
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            tx_busy <= 1'b0;
            state   <= TX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl: PS/2 mouse power-up sequencer.
// Runs reset (FF->FA), BAT (AA), ID (00), enable (F4->FA), with resend
// handling and sticky done/error status.
//   clk, rst_n             system clock, async active-low reset
//   start                  one-cycle pulse, accepted while busy=0
//   ps2_clk_in/data_in     raw pad inputs
//   clk_oe, data_oe        open-drain pull-low enables for the pads
//   rx_valid/rx_data/rx_err byte stream from the PS/2 receiver
//   tx_active              receiver must ignore the line while high
//   busy, done, error      sequence status (done/error sticky)
//   err_code               abort cause, valid while error=1
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TX_TIMEOUT     = 375000,
  parameter int RESP_TIMEOUT   = 25000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       clk_oe,
  output logic       data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       tx_active,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_code
);

  localparam int RW = $clog2(RESP_TIMEOUT + 1);
  localparam int TW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RW-1:0] RSP_LAST  = RW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRY);

  seq_state_e    state;
  logic [1:0]    step;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] retry;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic          tx_done;
  logic [1:0]    tx_err;
  logic          send_step;
  err_code_e     abort_code;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT_CYCLES),
    .TX_TIMEOUT     (TX_TIMEOUT)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .clk_oe      (clk_oe),
    .data_oe     (data_oe)
  );

  assign tx_active = tx_busy;
  assign send_step = (step == 2'd0) || (step == 2'd3);

  // Abort decode for this cycle (ERR_NONE = keep going). The receiver is only
  // listened to in SEQ_RESP, where the transmitter is always idle, so strobes
  // during a transmit are dropped. A byte outranks rx_err and the timeout.
  always_comb begin
    abort_code = ERR_NONE;
    case (state)
      SEQ_TX: begin
        if (tx_done) abort_code = err_code_e'({1'b0, tx_err});
      end
      SEQ_RESP: begin
        if (rx_valid) begin
          if (rx_data == step_rsp(step))
            abort_code = ERR_NONE;
          else if (rx_data == RSP_RESEND && send_step)
            abort_code = (retry == RETRY_MAX) ? ERR_RETRY : ERR_NONE;
          else if (rx_data == RSP_BAT_FAIL && step == 2'd1)
            abort_code = ERR_BAT;
          else
            abort_code = ERR_UNEXPECTED;
        end else if (rx_err) begin
          abort_code = ERR_RX;
        end else if (rcnt == RSP_LAST) begin
          abort_code = ERR_RESP_TIMEOUT;
        end
      end
      default: abort_code = ERR_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEQ_IDLE;
      step     <= '0;
      rcnt     <= '0;
      retry    <= '0;
      tx_start <= 1'b0;
      tx_byte  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      tx_start <= 1'b0;
      if (abort_code != ERR_NONE) begin
        busy     <= 1'b0;
        error    <= 1'b1;
        err_code <= abort_code;
        state    <= SEQ_IDLE;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (start) begin
              done     <= 1'b0;
              error    <= 1'b0;
              err_code <= ERR_NONE;
              busy     <= 1'b1;
              step     <= 2'd0;
              retry    <= '0;
              tx_byte  <= CMD_RESET;
              tx_start <= 1'b1;
              state    <= SEQ_TX;
            end
          end
          SEQ_TX: begin
            if (tx_done) begin
              rcnt  <= '0;
              state <= SEQ_RESP;
            end
          end
          SEQ_RESP: begin
            if (rx_valid) begin
              if (rx_data == step_rsp(step)) begin
                retry <= '0;
                rcnt  <= '0;
                case (step)
                  2'd2: begin
                    step     <= 2'd3;
                    tx_byte  <= CMD_ENABLE;
                    tx_start <= 1'b1;
                    state    <= SEQ_TX;
                  end
                  2'd3: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= SEQ_IDLE;
                  end
                  // S0->S1 and S1->S2: the next byte arrives unprompted.
                  default: step <= step + 1'b1;
                endcase
              end else begin
                // Only a resend on a send step survives the abort decode.
                retry    <= retry + 1'b1;
                tx_start <= 1'b1;
                state    <= SEQ_TX;
              end
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
module tb_ps2_mouse_init_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       clk_oe;
  logic       data_oe;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       tx_active;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_code;

  // Device side of the open-drain bus: 1 = released.
  logic dev_clk;
  logic dev_data;

  int checks;
  int fails;
  int ff_seen;

  logic [7:0] b;
  logic       p;
  logic       s;
  int         len;
  int         n;
  bit         ok;

  assign ps2_clk_in  = clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_in = data_oe ? 1'b0 : dev_data;

  always #5 clk = ~clk;

  ps2_mouse_init_ctrl #(
    .INHIBIT_CYCLES (10),
    .TX_TIMEOUT     (200),
    .RESP_TIMEOUT   (1000),
    .MAX_RETRY      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_oe      (clk_oe),
    .data_oe     (data_oe),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .tx_active   (tx_active),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Device model for one host-to-device byte: waits for inhibit and RTS,
  // then generates 11 clocks of 40 cycles, sampling data while clock is high.
  // rst_at != 0 asserts rst_n in the middle of that clock's low phase.
  task automatic dev_cmd(input bit ack, input int rst_at,
                         output logic [7:0] ob, output logic op, output logic os,
                         output int olen, output bit ook);
    logic [10:0] bits;
    int w;
    bits = '1;
    ook  = 1'b1;
    olen = 0;
    w    = 0;
    while (clk_oe !== 1'b1 && w < 300) begin tick(); w++; end
    if (clk_oe !== 1'b1) ook = 1'b0;
    while (ook && clk_oe === 1'b1 && olen < 300) begin olen++; tick(); end
    if (ook && data_oe !== 1'b1) ook = 1'b0;
    if (ook) begin
      repeat (5) tick();
      for (int i = 1; i <= 11; i++) begin
        if (i == 11 && ack) dev_data = 1'b0;
        dev_clk = 1'b0;
        if (i == rst_at) begin
          repeat (10) tick();
          rst_n = 1'b0;
          #2;
          break;
        end
        repeat (20) tick();
        dev_clk = 1'b1;
        repeat (10) tick();
        bits[i-1] = ps2_data_in;
        repeat (10) tick();
      end
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    ob = bits[7:0];
    op = bits[8];
    os = bits[9];
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] exp_b, input logic exp_p);
    logic [7:0] lb;
    logic       lp;
    logic       ls;
    int         ll;
    bit         lok;
    dev_cmd(1'b1, 0, lb, lp, ls, ll, lok);
    check({tag, "_seen"},    32'(lok), 32'd1);
    check({tag, "_inhibit"}, ll,       32'd10);
    check({tag, "_byte"},    32'(lb),  32'(exp_b));
    check({tag, "_parity"},  32'(lp),  32'(exp_p));
    check({tag, "_stop"},    32'(ls),  32'd1);
    if (lb == 8'hFF) ff_seen++;
  endtask

  // Receiver-side byte delivery once the transmitter has let go of the line.
  task automatic rsp(input logic [7:0] v);
    int w;
    w = 0;
    while (tx_active !== 1'b0 && w < 600) begin tick(); w++; end
    check("rsp_wait", 32'(w < 600), 32'd1);
    repeat (5) tick();
    rx_valid = 1'b1;
    rx_data  = v;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic full_seq(input string tag);
    start_pulse();
    do_cmd({tag, "_ff"}, 8'hFF, 1'b1);
    rsp(8'hFA);
    rsp(8'hAA);
    rsp(8'h00);
    do_cmd({tag, "_f4"}, 8'hF4, 1'b0);
    rsp(8'hFA);
    tick();
    check({tag, "_done"},  32'(done),  32'd1);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; fails = 0; ff_seen = 0;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) tick();
    check("rst_clk_oe",    32'(clk_oe),    32'd0);
    check("rst_data_oe",   32'(data_oe),   32'd0);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_err_code",  32'(err_code),  32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Happy path, with a start pulse ignored while waiting for the ID byte.
    start_pulse();
    do_cmd("hp_ff", 8'hFF, 1'b1);
    rsp(8'hFA);
    rsp(8'hAA);
    start_pulse();
    n = 0;
    repeat (30) begin tick(); if (clk_oe) n++; end
    check("busy_start_no_tx", n,            32'd0);
    check("busy_start_busy",  32'(busy),    32'd1);
    rsp(8'h00);
    do_cmd("hp_f4", 8'hF4, 1'b0);
    rsp(8'hFA);
    tick();
    check("hp_done",  32'(done),  32'd1);
    check("hp_busy",  32'(busy),  32'd0);
    check("hp_error", 32'(error), 32'd0);

    // Two resends of 0xFF, then a normal finish.
    ff_seen = 0;
    start_pulse();
    do_cmd("rs1", 8'hFF, 1'b1); rsp(8'hFE);
    do_cmd("rs2", 8'hFF, 1'b1); rsp(8'hFE);
    do_cmd("rs3", 8'hFF, 1'b1); rsp(8'hFA);
    rsp(8'hAA);
    rsp(8'h00);
    do_cmd("rs_f4", 8'hF4, 1'b0);
    rsp(8'hFA);
    tick();
    check("rs_ff_count", ff_seen,     32'd3);
    check("rs_done",     32'(done),   32'd1);

    // Four resends in a row exhaust the retry budget.
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      do_cmd("rx", 8'hFF, 1'b1);
      rsp(8'hFE);
    end
    tick();
    check("retry_error",    32'(error),    32'd1);
    check("retry_err_code", 32'(err_code), 32'd5);
    check("retry_busy",     32'(busy),     32'd0);

    // Start after an error clears status on acceptance; device stays silent.
    start_pulse();
    check("restart_error",    32'(error),    32'd0);
    check("restart_err_code", 32'(err_code), 32'd0);
    check("restart_busy",     32'(busy),     32'd1);
    n = 0;
    while (clk_oe !== 1'b1 && n < 300) begin tick(); n++; end
    n = 0;
    while (clk_oe === 1'b1 && n < 300) begin tick(); n++; end
    check("silent_rts", 32'(data_oe), 32'd1);
    n = 0;
    while (error !== 1'b1 && n < 400) begin tick(); n++; end
    check("silent_gap",       32'(n >= 200 && n <= 202), 32'd1);
    check("silent_err_code",  32'(err_code),  32'd1);
    check("silent_clk_oe",    32'(clk_oe),    32'd0);
    check("silent_data_oe",   32'(data_oe),   32'd0);
    check("silent_tx_active", 32'(tx_active), 32'd0);

    // BAT failure.
    start_pulse();
    do_cmd("bat_ff", 8'hFF, 1'b1);
    rsp(8'hFA);
    rsp(8'hFC);
    tick();
    check("bat_error",    32'(error),    32'd1);
    check("bat_err_code", 32'(err_code), 32'd7);

    // Wrong ID byte.
    start_pulse();
    do_cmd("id_ff", 8'hFF, 1'b1);
    rsp(8'hFA);
    rsp(8'hAA);
    rsp(8'h55);
    tick();
    check("id_error",    32'(error),    32'd1);
    check("id_err_code", 32'(err_code), 32'd4);

    // No line acknowledge on clock 11.
    start_pulse();
    dev_cmd(1'b0, 0, b, p, s, len, ok);
    tick();
    check("noack_seen",     32'(ok),        32'd1);
    check("noack_error",    32'(error),     32'd1);
    check("noack_err_code", 32'(err_code),  32'd2);
    check("noack_data_oe",  32'(data_oe),   32'd0);

    // Reset in the middle of the 5th bit.
    start_pulse();
    dev_cmd(1'b1, 5, b, p, s, len, ok);
    check("mid_rst_seen",      32'(ok),        32'd1);
    check("mid_rst_clk_oe",    32'(clk_oe),    32'd0);
    check("mid_rst_data_oe",   32'(data_oe),   32'd0);
    check("mid_rst_tx_active", 32'(tx_active), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_done",      32'(done),      32'd0);
    check("mid_rst_error",     32'(error),     32'd0);
    check("mid_rst_err_code",  32'(err_code),  32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    full_seq("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
